// File: rtl/gpio_bank_pkg.sv
// Shared definitions for the GPIO bank: register map and control FSM states.
package gpio_bank_pkg;

    localparam logic [2:0] ADDR_DIR      = 3'd0;
    localparam logic [2:0] ADDR_OUT      = 3'd1;
    localparam logic [2:0] ADDR_IN       = 3'd2;
    localparam logic [2:0] ADDR_IRQ_EN   = 3'd3;
    localparam logic [2:0] ADDR_IRQ_RISE = 3'd4;
    localparam logic [2:0] ADDR_PEND     = 3'd5;

    typedef enum logic {
        WARMUP = 1'b0,
        RUN    = 1'b1
    } state_t;

endpackage

// File: rtl/gpio_bank_chan.sv
// One GPIO input channel: synchroniser chain, debouncer and edge detector.
// rise_ev/fall_ev pulse on the cycle the debounced value is accepted.
module gpio_bank_chan #(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pad_in,
    output logic stable,
    output logic rise_ev,
    output logic fall_ev
);

    localparam int CW = (DEB_CYCLES > 0) ? $clog2(DEB_CYCLES + 1) : 1;

    logic [SYNC_STAGES-1:0] sync_chain;
    logic                   sync;
    logic                   accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_chain <= '0;
        end else begin
            sync_chain <= {sync_chain[SYNC_STAGES-2:0], pad_in};
        end
    end

    assign sync = sync_chain[SYNC_STAGES-1];

    generate
        if (DEB_CYCLES == 0) begin : g_nodeb
            assign accept = sync ^ stable;
        end else begin : g_deb
            localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);
            logic [CW-1:0] cnt;

            assign accept = (sync ^ stable) && (cnt == CNT_LAST);

            // Any return to the accepted level restarts the qualification window.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt <= '0;
                end else if ((sync == stable) || accept) begin
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable <= 1'b0;
        end else if (accept) begin
            stable <= sync;
        end
    end

    assign rise_ev = accept & sync;
    assign fall_ev = accept & ~sync;

endmodule

// File: rtl/gpio_bank.sv
// Bank of N_CH bidirectional GPIO channels with register interface,
// warm-up gated edge detection and write-1-to-clear interrupt pending bits.
module gpio_bank
    import gpio_bank_pkg::*;
#(
    parameter int N_CH        = 8,
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wr_en,
    input  logic            rd_en,
    input  logic [2:0]      addr,
    input  logic [N_CH-1:0] wdata,
    output logic [N_CH-1:0] rdata,
    output logic            irq,
    output logic [N_CH-1:0] pad_dir,
    output logic [N_CH-1:0] pad_out,
    input  logic [N_CH-1:0] pad_in
);

    localparam int WARM_LOAD = SYNC_STAGES + DEB_CYCLES + 1;
    localparam int WW        = $clog2(WARM_LOAD + 1);

    state_t          state;
    state_t          state_next;
    logic [WW-1:0]   warm_cnt;
    logic            edge_on;

    logic [N_CH-1:0] dir_q;
    logic [N_CH-1:0] out_q;
    logic [N_CH-1:0] irq_en_q;
    logic [N_CH-1:0] irq_rise_q;
    logic [N_CH-1:0] pend_q;

    logic [N_CH-1:0] stable;
    logic [N_CH-1:0] rise_ev;
    logic [N_CH-1:0] fall_ev;
    logic [N_CH-1:0] pend_set;
    logic [N_CH-1:0] pend_clr;
    logic [N_CH-1:0] rd_mux;

    generate
        for (genvar i = 0; i < N_CH; i++) begin : g_chan
            gpio_bank_chan #(
                .SYNC_STAGES (SYNC_STAGES),
                .DEB_CYCLES  (DEB_CYCLES)
            ) u_chan (
                .clk     (clk),
                .rst_n   (rst_n),
                .pad_in  (pad_in[i]),
                .stable  (stable[i]),
                .rise_ev (rise_ev[i]),
                .fall_ev (fall_ev[i])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= WARMUP;
        end else begin
            state <= state_next;
        end
    end

    // Warm-up covers the synchroniser and debouncer settling after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            warm_cnt <= WW'(WARM_LOAD);
        end else if (warm_cnt != '0) begin
            warm_cnt <= warm_cnt - 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            WARMUP:  if (warm_cnt <= WW'(1)) state_next = RUN;
            RUN:     state_next = RUN;
            default: state_next = WARMUP;
        endcase
    end

    always_comb begin
        edge_on = (state == RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_q      <= '0;
            out_q      <= '0;
            irq_en_q   <= '0;
            irq_rise_q <= '0;
        end else if (wr_en) begin
            case (addr)
                ADDR_DIR:      dir_q      <= wdata;
                ADDR_OUT:      out_q      <= wdata;
                ADDR_IRQ_EN:   irq_en_q   <= wdata;
                ADDR_IRQ_RISE: irq_rise_q <= wdata;
                default:       ;
            endcase
        end
    end

    // Output channels never raise interrupts, whatever their pad does.
    assign pend_set = {N_CH{edge_on}} & ~dir_q
                    & ((irq_rise_q & rise_ev) | (~irq_rise_q & fall_ev));
    assign pend_clr = (wr_en && (addr == ADDR_PEND)) ? wdata : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
        end else begin
            pend_q <= (pend_q & ~pend_clr) | pend_set;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (addr)
            ADDR_DIR:      rd_mux = dir_q;
            ADDR_OUT:      rd_mux = out_q;
            ADDR_IN:       rd_mux = stable;
            ADDR_IRQ_EN:   rd_mux = irq_en_q;
            ADDR_IRQ_RISE: rd_mux = irq_rise_q;
            ADDR_PEND:     rd_mux = pend_q;
            default:       rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (rd_en) begin
            rdata <= rd_mux;
        end
    end

    assign irq     = |(pend_q & irq_en_q);
    assign pad_dir = dir_q;
    assign pad_out = out_q;

endmodule
